// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared types and constants for the req/ack CDC handshake.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } hs_tx_state_t;

    // Width of a counter that must hold 0..limit, never narrower than 1 bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/DFF_META.sv
`default_nettype none
// ============================================================================
// Module      : DFF_META
// Description : Multi-flop metastability synchroniser for a single bit.
// Revision    : 1.0 - initial release
// ============================================================================
module DFF_META #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source side of a four-phase req/ack handshake for one word.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam int                c_CNT_W   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    hs_tx_state_t            r_state;
    logic                    r_req;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_done;
    logic                    r_timeout;
    logic                    r_busy;
    logic [c_CNT_W-1:0]      r_count;
    logic [SYNC_STAGES-1:0]  r_flush;
    logic                    w_ack_s;
    logic                    w_sat;
    logic                    w_expired;
    logic                    w_ready;

    DFF_META #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (ack_i),
        .o_q   (w_ack_s)
    );

    assign w_sat = (r_count == c_TIMEOUT);

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            assign w_expired = w_sat;
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    // The synchroniser restarts from 0 on reset, so its output is not a true
    // image of ack_i until it has refilled; hold off acceptance until then.
    assign w_ready = (r_state == IDLE) && !w_ack_s && (r_flush == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_flush   <= '1;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_flush   <= r_flush >> 1;
            case (r_state)
                IDLE: begin
                    if (in_valid && w_ready) begin
                        r_data  <= in_data;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // An ack edge on the expiry cycle takes priority.
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_count <= '0;
                        r_state <= RELEASE;
                    end else if (w_expired) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_count   <= '0;
                        r_state   <= ABORT;
                    end else if (!w_sat) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!w_ack_s) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_count   <= '0;
                        r_state   <= ABORT;
                    end else if (!w_sat) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                ABORT: begin
                    r_req <= 1'b0;
                    if (!w_ack_s) begin
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign req_o     = r_req;
    assign data_o    = r_data;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
    assign busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Directed self-checking bench for cdc_handshake_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;

    // Instance A: TIMEOUT_CYCLES=15, driven by a model destination or forced ack
    logic       in_valid_a = 1'b0;
    logic [7:0] in_data_a  = 8'h00;
    logic       in_ready_a, req_a, done_a, timeout_a, busy_a;
    logic [7:0] data_a;
    logic       ack_a;
    logic       model_ack = 1'b0;
    logic       force_ack = 1'b0;
    logic       dest_en   = 1'b0;
    assign ack_a = dest_en ? model_ack : force_ack;

    // Instance B: TIMEOUT_CYCLES=4, ack driven directly
    logic       in_valid_b = 1'b0;
    logic [7:0] in_data_b  = 8'h00;
    logic       in_ready_b, req_b, done_b, timeout_b, busy_b;
    logic [7:0] data_b;
    logic       ack_b = 1'b0;

    cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(15)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .req_o(req_a), .data_o(data_a), .ack_i(ack_a),
        .done_o(done_a), .timeout_o(timeout_a), .busy_o(busy_a)
    );

    cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .req_o(req_b), .data_o(data_b), .ack_i(ack_b),
        .done_o(done_b), .timeout_o(timeout_b), .busy_o(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Destination model: follows req_o with ack after 3 cycles in each direction.
    int dcnt = 0;
    always @(negedge clk) begin
        if (!dest_en) begin
            model_ack = 1'b0;
            dcnt      = 0;
        end else if (req_a != model_ack) begin
            dcnt++;
            if (dcnt >= 3) begin
                model_ack = req_a;
                dcnt      = 0;
            end
        end else begin
            dcnt = 0;
        end
    end

    // Event counters and data_o stability monitor.
    int         done_cnt_a = 0, to_cnt_a = 0, done_cnt_b = 0, to_cnt_b = 0;
    logic [7:0] done_q[$];
    logic       mon_en    = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_req  = 1'b0;
    logic       prev_busy = 1'b0;
    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            done_q.push_back(data_a);
        end
        if (timeout_a) to_cnt_a++;
        if (done_b)    done_cnt_b++;
        if (timeout_b) to_cnt_b++;
        if (mon_en && (data_a !== prev_data))
            check("data_change_only_on_accept", {31'd0, req_a && !prev_req && !prev_busy}, 32'd1);
        prev_data = data_a;
        prev_req  = req_a;
        prev_busy = busy_a;
    end

    task automatic send_a(input logic [7:0] word, input bit keep, input string tag);
        int n;
        in_valid_a = 1'b1;
        in_data_a  = word;
        n = 0;
        while (!in_ready_a && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready_a}, 32'd1);
        @(negedge clk);
        if (!keep) in_valid_a = 1'b0;
        check({tag, "_data"}, {24'd0, data_a}, {24'd0, word});
        check({tag, "_req"},  {31'd0, req_a},  32'd1);
    endtask

    task automatic send_b(input logic [7:0] word, input string tag);
        int n;
        in_valid_b = 1'b1;
        in_data_b  = word;
        n = 0;
        while (!in_ready_b && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready_b}, 32'd1);
        @(negedge clk);
        in_valid_b = 1'b0;
        check({tag, "_data"}, {24'd0, data_b}, {24'd0, word});
    endtask

    task automatic wait_done_a(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt_a < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_count"}, done_cnt_a, target);
    endtask

    initial begin
        int base_d, base_t, rc, n;

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(negedge clk);
        check("rst_req",     {31'd0, req_a},     32'd0);
        check("rst_data",    {24'd0, data_a},    32'd0);
        check("rst_done",    {31'd0, done_a},    32'd0);
        check("rst_timeout", {31'd0, timeout_a}, 32'd0);
        check("rst_busy",    {31'd0, busy_a},    32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ready_a", {31'd0, in_ready_a}, 32'd1);
        check("post_rst_ready_b", {31'd0, in_ready_b}, 32'd1);
        mon_en = 1'b1;

        // Basic transfer
        dest_en = 1'b1;
        send_a(8'hA5, 1'b0, "basic");
        wait_done_a(1, "basic");
        check("basic_done_word", {24'd0, done_q[0]}, 32'h0000_00A5);
        check("basic_req_low", {31'd0, req_a}, 32'd0);
        @(negedge clk);
        check("basic_done_pulse", {31'd0, done_a}, 32'd0);
        check("basic_ready_back", {31'd0, in_ready_a}, 32'd1);
        check("basic_data_held",  {24'd0, data_a}, 32'h0000_00A5);

        // Back-to-back with in_valid held
        done_q.delete();
        base_d = done_cnt_a;
        send_a(8'h01, 1'b1, "b2b1");
        send_a(8'h02, 1'b1, "b2b2");
        send_a(8'h03, 1'b0, "b2b3");
        wait_done_a(base_d + 3, "b2b");
        check("b2b_q_size", done_q.size(), 32'd3);
        if (done_q.size() == 3) begin
            check("b2b_word0", {24'd0, done_q[0]}, 32'd1);
            check("b2b_word1", {24'd0, done_q[1]}, 32'd2);
            check("b2b_word2", {24'd0, done_q[2]}, 32'd3);
        end
        repeat (3) @(negedge clk);
        dest_en = 1'b0;
        repeat (3) @(negedge clk);

        // Timeout with ack tied low
        base_d = done_cnt_a;
        base_t = to_cnt_a;
        send_a(8'h3C, 1'b0, "to");
        rc = 1;
        n  = 0;
        while (!timeout_a && n < 40) begin
            @(negedge clk);
            n++;
            if (req_a) rc++;
        end
        check("to_pulse",  {31'd0, timeout_a}, 32'd1);
        check("to_req_low", {31'd0, req_a}, 32'd0);
        check("to_req_cycles", {31'd0, (rc == 15) || (rc == 16)}, 32'd1);
        @(negedge clk);
        check("to_pulse_one_cycle", {31'd0, timeout_a}, 32'd0);
        n = 0;
        while (!in_ready_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_ready_back", {31'd0, in_ready_a}, 32'd1);
        check("to_idle", {31'd0, busy_a}, 32'd0);
        check("to_no_done", done_cnt_a, base_d);
        check("to_count", to_cnt_a, base_t + 1);

        // Late ack after abort
        force_ack = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i >= 2) check("late_ready_low", {31'd0, in_ready_a}, 32'd0);
        end
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ready_still_low", {31'd0, in_ready_a}, 32'd0);
        @(negedge clk);
        check("late_ready_high", {31'd0, in_ready_a}, 32'd1);
        check("late_no_done", done_cnt_a, base_d);
        check("late_no_busy", {31'd0, busy_a}, 32'd0);

        // Reset mid-REQ with ack high
        mon_en = 1'b0;
        send_a(8'h5A, 1'b0, "rstmid");
        force_ack = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_req",     {31'd0, req_a},      32'd0);
        check("rstmid_data",    {24'd0, data_a},     32'd0);
        check("rstmid_done",    {31'd0, done_a},     32'd0);
        check("rstmid_timeout", {31'd0, timeout_a},  32'd0);
        check("rstmid_busy",    {31'd0, busy_a},     32'd0);
        check("rstmid_ready",   {31'd0, in_ready_a}, 32'd0);
        in_valid_a = 1'b1;
        in_data_a  = 8'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstmid_hold_ready", {31'd0, in_ready_a}, 32'd0);
            check("rstmid_hold_busy",  {31'd0, busy_a},     32'd0);
        end
        in_valid_a = 1'b0;
        force_ack  = 1'b0;
        @(negedge clk);
        check("rstmid_ready_lag", {31'd0, in_ready_a}, 32'd0);
        @(negedge clk);
        check("rstmid_ready_back", {31'd0, in_ready_a}, 32'd1);
        check("rstmid_data_kept", {24'd0, data_a}, 32'd0);
        mon_en = 1'b1;

        // Collision: ack_s rises exactly on the expiry cycle (TIMEOUT_CYCLES=4)
        base_d = done_cnt_b;
        base_t = to_cnt_b;
        send_b(8'hC3, "col");
        repeat (2) @(negedge clk);
        ack_b = 1'b1;
        @(negedge clk);
        check("col_req_n3", {31'd0, req_b}, 32'd1);
        @(negedge clk);
        check("col_req_n4", {31'd0, req_b}, 32'd1);
        @(negedge clk);
        check("col_release_req", {31'd0, req_b},     32'd0);
        check("col_release_busy", {31'd0, busy_b},   32'd1);
        check("col_no_timeout", {31'd0, timeout_b},  32'd0);
        ack_b = 1'b0;
        n = 0;
        while (done_cnt_b < base_d + 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("col_done", done_cnt_b, base_d + 1);
        check("col_timeouts", to_cnt_b, base_t);

        // One cycle later the ack misses the window and the transfer aborts
        send_b(8'h3C, "late");
        repeat (3) @(negedge clk);
        ack_b = 1'b1;
        @(negedge clk);
        check("miss_req_n4", {31'd0, req_b}, 32'd1);
        @(negedge clk);
        check("miss_timeout", {31'd0, timeout_b}, 32'd1);
        check("miss_req_low", {31'd0, req_b},     32'd0);
        ack_b = 1'b0;
        n = 0;
        while (!in_ready_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("miss_ready_back", {31'd0, in_ready_b}, 32'd1);
        check("miss_no_done", done_cnt_b, base_d + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 ns");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
